// File: rtl/spart_rx_if.sv
// Receive-side bus of the SPART: serial line and baud tick in, received byte and status out.
interface spart_rx_if;
    logic       rxd;
    logic       enable;
    logic       clr_rda;
    logic [7:0] rx_data;
    logic       RDA;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    modport slave (
        input  rxd, enable, clr_rda,
        output rx_data, RDA, framing_err, overrun, busy
    );

    modport master (
        output rxd, enable, clr_rda,
        input  rx_data, RDA, framing_err, overrun, busy
    );
endinterface

// File: rtl/spart_rx_control.sv
// SPART receiver: 16x oversampled 8N1 deframer with RDA / framing / overrun status.
//
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge on rxd_s
//   START | counting to mid start bit to confirm it
//   DATA  | sampling 8 data bits LSB first, one per 16 enables
//   STOP  | sampling stop bit, then publishing the byte
module spart_rx_control (
    input  logic       clk,
    input  logic       rst,
    spart_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       r_rxd_meta;
    logic       r_rxd_s;
    logic [3:0] r_smp_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_rx_data;
    logic       r_rda;
    logic       r_framing_err;
    logic       r_overrun;
    logic       r_busy;

    logic       w_shift_en;
    logic       w_done;
    logic       w_bit_clr;
    logic       w_state_chg;

    // Synchronizer resets to the idle-high level so reset release is not seen as a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= bus.rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_done       = 1'b0;
        w_bit_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rxd_s) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (bus.enable && (r_smp_cnt == 4'd7)) begin
                    if (!r_rxd_s) begin
                        w_next_state = DATA;
                        w_bit_clr    = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            DATA: begin
                if (bus.enable && (r_smp_cnt == 4'd15)) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (bus.enable && (r_smp_cnt == 4'd15)) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_state_chg = (w_next_state != r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp_cnt <= 4'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if (w_state_chg) begin
                r_smp_cnt <= 4'd0;
            end else if (bus.enable) begin
                r_smp_cnt <= r_smp_cnt + 4'd1;
            end

            if (w_bit_clr) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift_en) begin
                r_shift <= {r_rxd_s, r_shift[7:1]};
            end
        end
    end

    // Byte completion takes priority over a host read landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data     <= 8'h00;
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (w_done) begin
            r_rx_data     <= r_shift;
            r_rda         <= 1'b1;
            r_framing_err <= ~r_rxd_s;
            if (r_rda && !bus.clr_rda) begin
                r_overrun <= 1'b1;
            end
        end else if (bus.clr_rda) begin
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
        end
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.RDA         = r_rda;
    assign bus.framing_err = r_framing_err;
    assign bus.overrun     = r_overrun;
    assign bus.busy        = r_busy;

endmodule

// File: doc/spart_rx_control.md
SPART_RX_CONTROL -- requirements
Module: spart_rx_control

Interface
Parameters: none. Oversample ratio is fixed at 16.
REQ-001 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rxd  in  1  serial receive line; idles high; asynchronous to clk.
- enable  in  1  one-clk pulse at 16x the baud rate, from the baud generator.
- clr_rda  in  1  one-clk read strobe; the host has consumed rx_data.
- rx_data  out  8  last received byte.
- RDA  out  1  receive data available.
- framing_err  out  1  the stop bit of the last byte sampled low.
- overrun  out  1  a byte completed while RDA was already 1.
- busy  out  1  a frame is in progress (state is not IDLE).

Function
REQ-002 rxd SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rxd_s.
REQ-003 The FSM SHALL have exactly four states: IDLE, START, DATA and STOP. The state register SHALL be separate from the next-state combinational logic.
REQ-004 A 4-bit sample counter SHALL increment only on enable, wrap from 15 to 0, and clear on every state transition.
REQ-005 A 3-bit bit index SHALL count the received data bits (0 to 7).
REQ-006 IDLE: when rxd_s is 0 on any clk (edge detect, not gated by enable), the FSM SHALL go to START with the sample counter cleared.
REQ-007 START: on the 8th enable (counter reaching 7, mid start bit), the FSM SHALL act as follows:
- rxd_s == 0: go to DATA with counter and bit index cleared.
- rxd_s == 1: false start; return to IDLE with no flag change.
REQ-008 DATA: on every 16th enable (counter reaching 15, mid bit), rxd_s SHALL shift into an 8-bit shift register, LSB first. After the 8th sample (bit index 7) the FSM SHALL go to STOP.
REQ-009 STOP: on the 16th enable, in the same cycle, the block SHALL:
- load rx_data from the shift register;
- set RDA = 1;
- set framing_err = ~rxd_s;
- set overrun = 1 if RDA was already 1 and clr_rda is 0, otherwise leave overrun unchanged;
- return to IDLE.
REQ-010 Byte completion SHALL load rx_data even when a framing error or an overrun occurs; the new byte overwrites the old one.
REQ-011 clr_rda SHALL clear RDA, framing_err and overrun on the following clk edge.
REQ-012 If clr_rda and byte completion fall in the same cycle, completion SHALL win: RDA = 1, framing_err reflects the new byte, and overrun is not set.
REQ-013 rx_data SHALL change only at byte completion and SHALL be held stable otherwise, including across clr_rda.
REQ-014 busy SHALL equal (state != IDLE), registered directly from the state flop.
REQ-015 With no enable pulses, the FSM SHALL hold its state and counters indefinitely. The only exception is the IDLE-to-START edge detect.
REQ-016 A new start bit SHALL be accepted in the first cycle after returning to IDLE; no extra idle gap is required.
REQ-017 Latency: RDA SHALL rise 1 clk after the enable that samples the stop bit. It is nominally 9.5 bit times plus 3 clk after the falling edge at rxd.

Reset
REQ-018 On rst assertion, asynchronously and independent of clk, the block SHALL force:
- state = IDLE;
- sample counter = 0 and bit index = 0;
- shift register = 0x00 and rx_data = 0x00;
- RDA = 0, framing_err = 0, overrun = 0, busy = 0;
- synchronizer flops = 1.
REQ-019 rst asserted mid-frame SHALL abandon the frame with no flag or data update. After release, the block SHALL wait for a fresh falling edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Nominal byte: rxd frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) -> rx_data = 0x55, RDA = 1, framing_err = 0, overrun = 0, busy = 0 after the stop bit.
- Framing error: byte 0xA3 with stop bit 0 -> rx_data = 0xA3, RDA = 1, framing_err = 1; then clr_rda pulse -> RDA = 0 and framing_err = 0 on the next clk.
- Overrun: two back-to-back frames 0x12 then 0x34, no clr_rda -> rx_data = 0x34, RDA = 1, overrun = 1.
- Simultaneous completion and read: clr_rda coincides with the stop-sample cycle of 0x7E -> RDA = 1, overrun = 0, rx_data = 0x7E.
- Glitch rejection: rxd low for 4 enable periods, then high -> busy pulses, returns to IDLE, RDA remains 0; a following valid 0xC9 frame is received correctly.
- Reset mid-frame: rst pulse during bit 3 of 0xFF -> all outputs at reset values, rx_data = 0x00, and no RDA until the next full frame.
